// File: rtl/vga_stream_tracker.sv
// Pixel-position tracker for the camera VGA stream: registered x/y with a pixel
// strobe, line/frame events, ROI and decimation flags, measured geometry and errors.
module vga_stream_tracker #(
  parameter int X_W       = 13,
  parameter int Y_W       = 13,
  parameter int FC_W      = 16,
  parameter int DEC_SHIFT = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iVGA_HS,
  input  logic            iVGA_VS,
  input  logic            iVGA_BLANK_N,
  input  logic [X_W-1:0]  roi_x0,
  input  logic [X_W-1:0]  roi_x1,
  input  logic [Y_W-1:0]  roi_y0,
  input  logic [Y_W-1:0]  roi_y1,
  output logic [X_W-1:0]  x_count,
  output logic [Y_W-1:0]  y_count,
  output logic            pix_valid,
  output logic            dec_valid,
  output logic            roi_hit,
  output logic            line_end,
  output logic            frame_start,
  output logic            frame_end,
  output logic [FC_W-1:0] frame_count,
  output logic [X_W-1:0]  meas_width,
  output logic [Y_W-1:0]  meas_height,
  output logic            line_err,
  output logic            ovf_err
);

  typedef enum logic [1:0] {WAIT_VS, VBLANK, ACTIVE} state_t;

  localparam logic [X_W-1:0] X_DMASK = X_W'((32'd1 << DEC_SHIFT) - 32'd1);
  localparam logic [Y_W-1:0] Y_DMASK = Y_W'((32'd1 << DEC_SHIFT) - 32'd1);

  state_t         state_q, state_d;
  logic           act, act_q, act_d;
  logic [X_W-1:0] xc_q, xc_d, width_cur_q, width_cur_d;
  logic [Y_W-1:0] yc_q, yc_d;
  logic           first_done_q, first_done_d, any_pix_q, any_pix_d;
  logic           lerr_acc_q, lerr_acc_d, oerr_acc_q, oerr_acc_d;
  logic [X_W-1:0] sx0_q, sx0_d, sx1_q, sx1_d;
  logic [Y_W-1:0] sy0_q, sy0_d, sy1_q, sy1_d;

  logic [X_W-1:0]  x_count_q, x_count_d, meas_width_q, meas_width_d;
  logic [Y_W-1:0]  y_count_q, y_count_d, meas_height_q, meas_height_d;
  logic            pix_valid_q, pix_valid_d, dec_valid_q, dec_valid_d;
  logic            roi_hit_q, roi_hit_d, line_end_q, line_end_d;
  logic            frame_start_q, frame_start_d, frame_end_q, frame_end_d;
  logic [FC_W-1:0] frame_count_q, frame_count_d;
  logic            line_err_q, line_err_d, ovf_err_q, ovf_err_d;

  logic [Y_W-1:0] lines_v;
  logic [X_W-1:0] width_v;
  logic           le_v, oe_v, in_roi, dec_hit;

  assign act = iVGA_VS & iVGA_HS & iVGA_BLANK_N;

  // Evaluated on the live counters, which become x_count/y_count next cycle.
  assign in_roi  = (xc_q >= sx0_q) && (xc_q <= sx1_q) && (yc_q >= sy0_q) && (yc_q <= sy1_q);
  assign dec_hit = ((xc_q & X_DMASK) == '0) && ((yc_q & Y_DMASK) == '0);

  always_comb begin
    state_d       = state_q;
    act_d         = act;
    xc_d          = xc_q;
    yc_d          = yc_q;
    width_cur_d   = width_cur_q;
    first_done_d  = first_done_q;
    any_pix_d     = any_pix_q;
    lerr_acc_d    = lerr_acc_q;
    oerr_acc_d    = oerr_acc_q;
    sx0_d         = sx0_q;
    sx1_d         = sx1_q;
    sy0_d         = sy0_q;
    sy1_d         = sy1_q;
    x_count_d     = x_count_q;
    y_count_d     = y_count_q;
    pix_valid_d   = 1'b0;
    dec_valid_d   = 1'b0;
    roi_hit_d     = 1'b0;
    line_end_d    = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    frame_count_d = frame_count_q;
    meas_width_d  = meas_width_q;
    meas_height_d = meas_height_q;
    line_err_d    = line_err_q;
    ovf_err_d     = ovf_err_q;
    lines_v       = yc_q;
    width_v       = width_cur_q;
    le_v          = lerr_acc_q;
    oe_v          = oerr_acc_q;

    case (state_q)
      WAIT_VS: begin
        if (!iVGA_VS) state_d = VBLANK;
      end
      VBLANK: begin
        if (iVGA_VS) begin
          state_d       = ACTIVE;
          frame_start_d = 1'b1;
          sx0_d         = roi_x0;
          sx1_d         = roi_x1;
          sy0_d         = roi_y0;
          sy1_d         = roi_y1;
          xc_d          = '0;
          yc_d          = '0;
          first_done_d  = 1'b0;
          any_pix_d     = 1'b0;
          lerr_acc_d    = 1'b0;
          oerr_acc_d    = 1'b0;
          line_err_d    = 1'b0;
          ovf_err_d     = 1'b0;
        end
      end
      ACTIVE: begin
        if (!iVGA_VS) begin
          state_d = VBLANK;
          // A line cut short by VS still counts toward height and the width check.
          if (act_q) begin
            if (yc_q == '1) oe_v = 1'b1;
            else            lines_v = yc_q + Y_W'(1);
            if (first_done_q) le_v = le_v | (xc_q != width_cur_q);
            else              width_v = xc_q;
          end
          if (any_pix_q) begin
            frame_end_d   = 1'b1;
            frame_count_d = frame_count_q + FC_W'(1);
            meas_height_d = lines_v;
            meas_width_d  = width_v;
            line_err_d    = le_v;
            ovf_err_d     = oe_v;
          end
        end else if (act) begin
          pix_valid_d = 1'b1;
          dec_valid_d = dec_hit;
          roi_hit_d   = in_roi;
          x_count_d   = xc_q;
          y_count_d   = yc_q;
          any_pix_d   = 1'b1;
          if (xc_q == '1) oerr_acc_d = 1'b1;
          else            xc_d = xc_q + X_W'(1);
        end else if (act_q) begin
          line_end_d = 1'b1;
          xc_d       = '0;
          if (yc_q == '1) oerr_acc_d = 1'b1;
          else            yc_d = yc_q + Y_W'(1);
          if (!first_done_q) begin
            width_cur_d  = xc_q;
            first_done_d = 1'b1;
          end else if (xc_q != width_cur_q) begin
            lerr_acc_d = 1'b1;
          end
        end
      end
      default: state_d = WAIT_VS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WAIT_VS;
      act_q         <= 1'b0;
      xc_q          <= '0;
      yc_q          <= '0;
      width_cur_q   <= '0;
      first_done_q  <= 1'b0;
      any_pix_q     <= 1'b0;
      lerr_acc_q    <= 1'b0;
      oerr_acc_q    <= 1'b0;
      sx0_q         <= '0;
      sx1_q         <= '0;
      sy0_q         <= '0;
      sy1_q         <= '0;
      x_count_q     <= '0;
      y_count_q     <= '0;
      pix_valid_q   <= 1'b0;
      dec_valid_q   <= 1'b0;
      roi_hit_q     <= 1'b0;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_count_q <= '0;
      meas_width_q  <= '0;
      meas_height_q <= '0;
      line_err_q    <= 1'b0;
      ovf_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      act_q         <= act_d;
      xc_q          <= xc_d;
      yc_q          <= yc_d;
      width_cur_q   <= width_cur_d;
      first_done_q  <= first_done_d;
      any_pix_q     <= any_pix_d;
      lerr_acc_q    <= lerr_acc_d;
      oerr_acc_q    <= oerr_acc_d;
      sx0_q         <= sx0_d;
      sx1_q         <= sx1_d;
      sy0_q         <= sy0_d;
      sy1_q         <= sy1_d;
      x_count_q     <= x_count_d;
      y_count_q     <= y_count_d;
      pix_valid_q   <= pix_valid_d;
      dec_valid_q   <= dec_valid_d;
      roi_hit_q     <= roi_hit_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      frame_count_q <= frame_count_d;
      meas_width_q  <= meas_width_d;
      meas_height_q <= meas_height_d;
      line_err_q    <= line_err_d;
      ovf_err_q     <= ovf_err_d;
    end
  end

  assign x_count     = x_count_q;
  assign y_count     = y_count_q;
  assign pix_valid   = pix_valid_q;
  assign dec_valid   = dec_valid_q;
  assign roi_hit     = roi_hit_q;
  assign line_end    = line_end_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign frame_count = frame_count_q;
  assign meas_width  = meas_width_q;
  assign meas_height = meas_height_q;
  assign line_err    = line_err_q;
  assign ovf_err     = ovf_err_q;

endmodule
